// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, sizes and byte helper for the AES byte driver
package aes_pkg;

    localparam int NUM_BYTES = 16;
    localparam int BYTE_W    = 8;
    localparam int BLOCK_W   = NUM_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COLLECT = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    // Byte i of a block, byte 0 being the most significant
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [3:0] idx);
        byte_sel = blk[(BLOCK_W - 1 - BYTE_W * int'(idx)) -: BYTE_W];
    endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// rtl/aes_byte_shifter.sv - parallel-load, byte-wide MSB-first shift register lanes
module aes_byte_shifter
    import aes_pkg::*;
#(
    parameter int LANES = 2,
    parameter int OUT_W = BLOCK_W
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             load_i,
    input  logic                             shift_i,
    input  logic [LANES-1:0][BLOCK_W-1:0]    load_data_i,
    input  logic [LANES-1:0][BYTE_W-1:0]     shift_in_i,
    output logic [LANES-1:0][OUT_W-1:0]      data_o
);

    logic [LANES-1:0][BLOCK_W-1:0] data_q, data_d;

    // Clear wins over load, load wins over shift; every lane moves together
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            for (int l = 0; l < LANES; l++) begin
                data_d[l] = {data_q[l][BLOCK_W-BYTE_W-1:0], shift_in_i[l]};
            end
        end
    end

    // Lane storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Only the top OUT_W bits of each lane are visible to the user
    always_comb begin
        data_o = '0;
        for (int l = 0; l < LANES; l++) begin
            data_o[l] = data_q[l][BLOCK_W-1 -: OUT_W];
        end
    end

endmodule

// File: rtl/aes_byte_driver.sv
// rtl/aes_byte_driver.sv - host-side byte-serial initiator for the masked AES core
module aes_byte_driver
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 512,
    parameter bit UNMASK  = 1'b0
) (
    input  logic                ClkxCI,
    input  logic                RstxBI,
    input  logic [BLOCK_W-1:0]  PTxDI,
    input  logic [BLOCK_W-1:0]  KxDI,
    input  logic [23:0]         RndxDI,
    input  logic                InValidxSI,
    output logic                InReadyxSO,
    output logic [BLOCK_W-1:0]  CxDO0,
    output logic [BLOCK_W-1:0]  CxDO1,
    output logic                OutValidxSO,
    input  logic                OutReadyxSI,
    output logic                BusyxSO,
    output logic                ErrxSO,
    output logic [BYTE_W-1:0]   CorePT0xDO,
    output logic [BYTE_W-1:0]   CorePT1xDO,
    output logic [BYTE_W-1:0]   CoreR0xDO,
    output logic [BYTE_W-1:0]   CoreR1xDO,
    output logic [BYTE_W-1:0]   CoreKxDO,
    output logic                CoreStartxSO,
    input  logic [BYTE_W-1:0]   CoreC0xDI,
    input  logic [BYTE_W-1:0]   CoreC1xDI,
    input  logic                CoreDonexSI
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;

    logic feed_load, feed_shift, feed_clear;
    logic cap_shift, cap_clear;

    // Lane 0 carries plaintext, lane 1 carries key / share1 in the capture copy
    logic [1:0][BYTE_W-1:0]  feed_byte;
    logic [1:0][BLOCK_W-1:0] cap_data;

    aes_byte_shifter #(
        .LANES (2),
        .OUT_W (BYTE_W)
    ) u_feed (
        .clk_i       (ClkxCI),
        .rst_ni      (RstxBI),
        .clear_i     (feed_clear),
        .load_i      (feed_load),
        .shift_i     (feed_shift),
        .load_data_i ({KxDI, PTxDI}),
        .shift_in_i  ('0),
        .data_o      (feed_byte)
    );

    aes_byte_shifter #(
        .LANES (2),
        .OUT_W (BLOCK_W)
    ) u_capture (
        .clk_i       (ClkxCI),
        .rst_ni      (RstxBI),
        .clear_i     (cap_clear),
        .load_i      (1'b0),
        .shift_i     (cap_shift),
        .load_data_i ('0),
        .shift_in_i  ({CoreC1xDI, CoreC0xDI}),
        .data_o      (cap_data)
    );

    // Control state, byte counter, watchdog and sticky error
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and shift-register control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        feed_load  = 1'b0;
        feed_shift = 1'b0;
        feed_clear = 1'b0;
        cap_shift  = 1'b0;
        cap_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (InValidxSI) begin
                    feed_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                feed_shift = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // Nothing of the block may remain once it is inside the core
                    feed_clear = 1'b1;
                    wdog_d     = WD_LOAD;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q - WD_LAST;
                if (CoreDonexSI) begin
                    cap_shift = 1'b1;
                    cnt_d     = 4'd1;
                    state_d   = ST_COLLECT;
                end else if (wdog_q == WD_LAST) begin
                    err_d      = 1'b1;
                    feed_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                cap_shift = 1'b1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (OutReadyxSI) begin
                    cap_clear  = 1'b1;
                    feed_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: core wires carry data only during LOAD, results only during HOLD
    always_comb begin
        InReadyxSO   = (state_q == ST_IDLE);
        BusyxSO      = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_COLLECT);
        OutValidxSO  = (state_q == ST_HOLD);
        ErrxSO       = err_q;
        CorePT0xDO   = '0;
        CorePT1xDO   = '0;
        CoreR0xDO    = '0;
        CoreR1xDO    = '0;
        CoreKxDO     = '0;
        CoreStartxSO = 1'b0;
        CxDO0        = '0;
        CxDO1        = '0;
        if (state_q == ST_LOAD) begin
            CorePT0xDO   = RndxDI[7:0];
            CorePT1xDO   = RndxDI[7:0] ^ feed_byte[0];
            CoreR0xDO    = RndxDI[15:8];
            CoreR1xDO    = RndxDI[23:16];
            CoreKxDO     = feed_byte[1];
            CoreStartxSO = (cnt_q == 4'd0);
        end
        if (state_q == ST_HOLD) begin
            if (UNMASK) begin
                CxDO0 = cap_data[0] ^ cap_data[1];
                CxDO1 = '0;
            end else begin
                CxDO0 = cap_data[0];
                CxDO1 = cap_data[1];
            end
        end
    end

endmodule

// File: tb/tb_aes_byte_driver.sv
// tb/tb_aes_byte_driver.sv - self-checking bench for aes_byte_driver with a behavioural AES core
module tb_aes_byte_driver;

    logic         ClkxCI;
    logic         RstxBI;
    logic [127:0] PTxDI, KxDI;
    logic [23:0]  RndxDI;
    logic         InValidxSI, OutReadyxSI;
    logic [7:0]   CoreC0xDI, CoreC1xDI;
    logic         CoreDonexSI;
    logic         core_done_m, stray_done;

    logic         InReadyxSO, OutValidxSO, BusyxSO, ErrxSO, CoreStartxSO;
    logic [127:0] CxDO0, CxDO1;
    logic [7:0]   CorePT0xDO, CorePT1xDO, CoreR0xDO, CoreR1xDO, CoreKxDO;

    logic         u_InReadyxSO, u_OutValidxSO, u_BusyxSO, u_ErrxSO, u_CoreStartxSO;
    logic [127:0] u_CxDO0, u_CxDO1;
    logic [7:0]   u_CorePT0xDO, u_CorePT1xDO, u_CoreR0xDO, u_CoreR1xDO, u_CoreKxDO;

    assign CoreDonexSI = core_done_m | stray_done;

    int total = 0;
    int bad   = 0;

    logic [127:0] cur_pt, cur_key;
    logic         rnd_zero, core_never;

    aes_byte_driver #(.TIMEOUT(512), .UNMASK(1'b0)) dut (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .PTxDI(PTxDI), .KxDI(KxDI), .RndxDI(RndxDI),
        .InValidxSI(InValidxSI), .InReadyxSO(InReadyxSO), .CxDO0(CxDO0), .CxDO1(CxDO1),
        .OutValidxSO(OutValidxSO), .OutReadyxSI(OutReadyxSI), .BusyxSO(BusyxSO), .ErrxSO(ErrxSO),
        .CorePT0xDO(CorePT0xDO), .CorePT1xDO(CorePT1xDO), .CoreR0xDO(CoreR0xDO),
        .CoreR1xDO(CoreR1xDO), .CoreKxDO(CoreKxDO), .CoreStartxSO(CoreStartxSO),
        .CoreC0xDI(CoreC0xDI), .CoreC1xDI(CoreC1xDI), .CoreDonexSI(CoreDonexSI)
    );

    aes_byte_driver #(.TIMEOUT(512), .UNMASK(1'b1)) dut_unmask (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .PTxDI(PTxDI), .KxDI(KxDI), .RndxDI(RndxDI),
        .InValidxSI(InValidxSI), .InReadyxSO(u_InReadyxSO), .CxDO0(u_CxDO0), .CxDO1(u_CxDO1),
        .OutValidxSO(u_OutValidxSO), .OutReadyxSI(OutReadyxSI), .BusyxSO(u_BusyxSO), .ErrxSO(u_ErrxSO),
        .CorePT0xDO(u_CorePT0xDO), .CorePT1xDO(u_CorePT1xDO), .CoreR0xDO(u_CoreR0xDO),
        .CoreR1xDO(u_CoreR1xDO), .CoreKxDO(u_CoreKxDO), .CoreStartxSO(u_CoreStartxSO),
        .CoreC0xDI(CoreC0xDI), .CoreC1xDI(CoreC1xDI), .CoreDonexSI(CoreDonexSI)
    );

    initial ClkxCI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference AES-128 (FIPS-197 arithmetic) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row+4*c] = t[row + 4*((c+row)%4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- fresh randomness, changed just after each rising edge ----------------
    always @(posedge ClkxCI) begin
        #1;
        RndxDI = rnd_zero ? 24'h0 : 24'($urandom);
    end

    // ---------------- behavioural two-share core ----------------
    int           m_in_idx  = -1;
    int           m_out_idx = -1;
    int           m_lat     = 0;
    logic [127:0] m_pt, m_key, m_ct;
    logic [7:0]   m_mask;

    always @(negedge ClkxCI) begin
        if (!RstxBI) begin
            m_in_idx    = -1;
            m_out_idx   = -1;
            m_lat       = 0;
            core_done_m = 1'b0;
            CoreC0xDI   = 8'h00;
            CoreC1xDI   = 8'h00;
        end else begin
            if (m_lat > 0) begin
                m_lat--;
                if (m_lat == 0) m_out_idx = 0;
            end
            if (m_out_idx >= 0) begin
                m_mask      = 8'($urandom);
                CoreC0xDI   = m_mask;
                CoreC1xDI   = m_mask ^ m_ct[127-8*m_out_idx -: 8];
                core_done_m = (m_out_idx == 0);
                m_out_idx++;
                if (m_out_idx == 16) m_out_idx = -1;
            end else begin
                core_done_m = 1'b0;
                CoreC0xDI   = 8'h00;
                CoreC1xDI   = 8'h00;
            end
            if (CoreStartxSO) m_in_idx = 0;
            if (m_in_idx >= 0) begin
                chk("start_pulse", CoreStartxSO, m_in_idx == 0);
                chk("pt_shares", CorePT0xDO ^ CorePT1xDO, cur_pt[127-8*m_in_idx -: 8]);
                chk("pt0_is_rnd", CorePT0xDO, RndxDI[7:0]);
                chk("key_byte", CoreKxDO, cur_key[127-8*m_in_idx -: 8]);
                chk("r_bytes", {CoreR1xDO, CoreR0xDO}, RndxDI[23:8]);
                m_pt[127-8*m_in_idx -: 8]  = CorePT0xDO ^ CorePT1xDO;
                m_key[127-8*m_in_idx -: 8] = CoreKxDO;
                m_in_idx++;
                if (m_in_idx == 16) begin
                    m_in_idx = -1;
                    m_ct     = aes_ref(m_pt, m_key);
                    if (!core_never) m_lat = 10;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(negedge ClkxCI);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] last_c0, last_c1, last_u0;

    task automatic accept_block(input logic [127:0] pt, input logic [127:0] key);
        int n = 0;
        cur_pt  = pt;
        cur_key = key;
        while (!InReadyxSO && n < 100) begin tick(); n++; end
        chk("in_ready_before", InReadyxSO, 1'b1);
        PTxDI      = pt;
        KxDI       = key;
        InValidxSI = 1'b1;
        tick();
        InValidxSI = 1'b0;
        PTxDI      = '0;
        KxDI       = '0;
        chk("start_first_load", CoreStartxSO, 1'b1);
        chk("busy_load", BusyxSO, 1'b1);
        chk("in_ready_load", InReadyxSO, 1'b0);
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input int bp_cycles, input int stray_at);
        logic [127:0] exp;
        int n;
        exp = aes_ref(pt, key);
        accept_block(pt, key);
        for (int i = 1; i < 16; i++) begin
            tick();
            stray_done = (i == stray_at);
        end
        tick();
        stray_done = 1'b0;
        chk("core_key_idle", CoreKxDO, 8'h00);
        chk("core_pt1_idle", CorePT1xDO, 8'h00);
        chk("busy_wait", BusyxSO, 1'b1);
        n = 0;
        while (!OutValidxSO && n < 200) begin tick(); n++; end
        chk("out_valid_seen", OutValidxSO, 1'b1);
        chk("ct_shares", CxDO0 ^ CxDO1, exp);
        chk("ct_unmask_c0", u_CxDO0, exp);
        chk("ct_unmask_c1", u_CxDO1, 128'h0);
        last_c0 = CxDO0;
        last_c1 = CxDO1;
        last_u0 = u_CxDO0;
        for (int i = 0; i < bp_cycles; i++) begin
            tick();
            chk("bp_valid", OutValidxSO, 1'b1);
            chk("bp_in_ready", InReadyxSO, 1'b0);
            chk("bp_stable", {CxDO0 ^ last_c0} | {CxDO1 ^ last_c1}, 128'h0);
        end
        OutReadyxSI = 1'b1;
        tick();
        OutReadyxSI = 1'b0;
        chk("valid_drop", OutValidxSO, 1'b0);
        chk("in_ready_after", InReadyxSO, 1'b1);
    endtask

    initial begin
        int n;
        logic saw_valid;
        RstxBI      = 1'b0;
        PTxDI       = '0;
        KxDI        = '0;
        RndxDI      = '0;
        InValidxSI  = 1'b0;
        OutReadyxSI = 1'b0;
        stray_done  = 1'b0;
        core_done_m = 1'b0;
        CoreC0xDI   = '0;
        CoreC1xDI   = '0;
        rnd_zero    = 1'b0;
        core_never  = 1'b0;
        cur_pt      = '0;
        cur_key     = '0;
        tick();
        tick();
        chk("rst_in_ready", InReadyxSO, 1'b1);
        chk("rst_out_valid", OutValidxSO, 1'b0);
        chk("rst_busy", BusyxSO, 1'b0);
        chk("rst_err", ErrxSO, 1'b0);
        chk("rst_start", CoreStartxSO, 1'b0);
        chk("rst_c0", CxDO0, 128'h0);
        RstxBI = 1'b1;
        tick();

        // FIPS-197 vector, random masks
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 0, -1);
        chk("fips_unmask", last_u0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Same vector with zero randomness
        rnd_zero = 1'b1;
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 0, -1);
        chk("fips_masked", last_c0 ^ last_c1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        rnd_zero = 1'b0;

        // Random blocks, one with 50 cycles of backpressure, one with a stray done in LOAD
        run_block(rand128(), rand128(), 50, -1);
        for (int b = 0; b < 3; b++) run_block(rand128(), rand128(), int'($urandom_range(0, 3)), -1);
        run_block(rand128(), rand128(), 0, 5);
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 0, 0);
        chk("stray_fips", last_u0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Reset while the ciphertext is being collected (byte 7 on the wires)
        accept_block(rand128(), rand128());
        n = 0;
        while (m_out_idx != 8 && n < 200) begin tick(); n++; end
        chk("reached_byte7", m_out_idx, 8);
        RstxBI = 1'b0;
        #1;
        chk("mid_rst_in_ready", InReadyxSO, 1'b1);
        chk("mid_rst_busy", BusyxSO, 1'b0);
        chk("mid_rst_valid", OutValidxSO, 1'b0);
        chk("mid_rst_c0", CxDO0, 128'h0);
        tick();
        tick();
        RstxBI = 1'b1;
        tick();
        run_block(rand128(), rand128(), 0, -1);

        // Core that never finishes: watchdog expiry
        core_never = 1'b1;
        accept_block(rand128(), rand128());
        for (int i = 0; i < 16; i++) tick();
        n = 0;
        saw_valid = 1'b0;
        while (BusyxSO && n < 1000) begin
            if (OutValidxSO) saw_valid = 1'b1;
            n++;
            tick();
        end
        chk("wait_cycles", n, 512);
        chk("timeout_err", ErrxSO, 1'b1);
        chk("timeout_idle", InReadyxSO, 1'b1);
        chk("timeout_no_valid", saw_valid | OutValidxSO, 1'b0);
        core_never = 1'b0;

        // Error flag stays set while later blocks complete normally
        run_block(rand128(), rand128(), 1, -1);
        chk("err_sticky", ErrxSO, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
